// File: rtl/dma_fifo.sv
// Single-clock data FIFO between the DMA read-response path and the write-data path.
// Registered read port; flags derive from registered wrap-bit pointers; sticky ovf/udf.
module dma_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    fifo_wen,
  input  logic [DATA_WIDTH-1:0]   fifo_wdata,
  input  logic                    fifo_rden,
  output logic [DATA_WIDTH-1:0]   fifo_rdata,
  output logic                    fifo_is_empty,
  output logic                    fifo_is_full,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    ovf,
  output logic                    udf
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full_s, empty_s, wr_acc_s, rd_acc_s;
  logic [ADDR_W:0]       count_s;

  // Status from registered pointers; acceptance uses current-cycle flags only.
  always_comb begin
    empty_s  = (wr_ptr_q == rd_ptr_q);
    full_s   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
               (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    count_s  = wr_ptr_q - rd_ptr_q;
    wr_acc_s = fifo_wen  & ~full_s  & ~flush;
    rd_acc_s = fifo_rden & ~empty_s & ~flush;
  end

  // Next-state for pointers, read data and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdata_d  = rdata_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = {(ADDR_W+1){1'b0}};
      rd_ptr_d = {(ADDR_W+1){1'b0}};
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
        rdata_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
      end else begin
        rd_ptr_d = rd_ptr_q;
        rdata_d  = rdata_q;
      end
      ovf_d = ovf_q | (fifo_wen  & full_s);
      udf_d = udf_q | (fifo_rden & empty_s);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {(ADDR_W+1){1'b0}};
      rd_ptr_q <= {(ADDR_W+1){1'b0}};
      rdata_q  <= {DATA_WIDTH{1'b0}};
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !rst) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= fifo_wdata;
    end
  end

  assign fifo_rdata    = rdata_q;
  assign fifo_is_empty = empty_s;
  assign fifo_is_full  = full_s;
  assign fifo_count    = count_s;
  assign ovf           = ovf_q;
  assign udf           = udf_q;

endmodule

// File: tb/tb_dma_fifo.sv
// Scoreboard bench for dma_fifo: stimulus pushes expected read data, a monitor pops and compares.
module tb_dma_fifo;

  logic        clk = 1'b0;
  logic        rst, flush, fifo_wen, fifo_rden;
  logic [31:0] fifo_wdata, fifo_rdata;
  logic        fifo_is_empty, fifo_is_full, ovf, udf;
  logic [6:0]  fifo_count;

  dma_fifo #(.DATA_WIDTH(32), .DEPTH(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_rden(fifo_rden),
    .fifo_rdata(fifo_rdata), .fifo_is_empty(fifo_is_empty), .fifo_is_full(fifo_is_full),
    .fifo_count(fifo_count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] mq [$];
  logic [31:0] exp_q [$];
  logic [31:0] rdata_m;
  logic        ovf_m, udf_m;
  logic        pend_rd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: after each cycle in which a read should be accepted, compare new read data.
  always @(posedge clk) begin
    if (pend_rd) begin
      #1;
      if (exp_q.size() == 0) check("rdata_underrun", 32'd1, 32'd0);
      else check("rdata", fifo_rdata, exp_q.pop_front());
    end
  end

  task automatic step(input logic r, input logic f, input logic w,
                      input logic [31:0] wd, input logic rd);
    logic fm, em, wacc, racc;
    rst = r; flush = f; fifo_wen = w; fifo_wdata = wd; fifo_rden = rd;
    wacc = 1'b0; racc = 1'b0;
    if (r) begin
      mq.delete(); ovf_m = 1'b0; udf_m = 1'b0; rdata_m = 32'h0;
    end else if (f) begin
      mq.delete(); ovf_m = 1'b0; udf_m = 1'b0;
    end else begin
      fm = (mq.size() == 64);
      em = (mq.size() == 0);
      wacc = w & ~fm;
      racc = rd & ~em;
      if (w & fm)  ovf_m = 1'b1;
      if (rd & em) udf_m = 1'b1;
      if (racc) begin
        rdata_m = mq.pop_front();
        exp_q.push_back(rdata_m);
      end
      if (wacc) mq.push_back(wd);
    end
    pend_rd = racc;
    @(posedge clk);
    @(negedge clk);
    pend_rd = 1'b0;
    check("count", {25'd0, fifo_count}, mq.size());
    check("empty", {31'd0, fifo_is_empty}, {31'd0, (mq.size() == 0)});
    check("full",  {31'd0, fifo_is_full},  {31'd0, (mq.size() == 64)});
    check("ovf",   {31'd0, ovf}, {31'd0, ovf_m});
    check("udf",   {31'd0, udf}, {31'd0, udf_m});
    if (!racc) check("rdata_hold", fifo_rdata, rdata_m);
  endtask

  initial begin
    int nw, iter;
    logic w, r;
    rst = 1'b1; flush = 1'b0; fifo_wen = 1'b0; fifo_rden = 1'b0; fifo_wdata = 32'h0;

    // Reset
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_rdata", fifo_rdata, 32'h0);
    check("rst_empty", {31'd0, fifo_is_empty}, 32'd1);

    // Ordering
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 32'h11 + i, 1'b0);
    check("ord_count8", {25'd0, fifo_count}, 32'd8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("ord_last", fifo_rdata, 32'h18);
    check("ord_empty", {31'd0, fifo_is_empty}, 32'd1);

    // Full, then write+read at full: write dropped
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 1'b1, 32'h100 + i, 1'b0);
    check("full_flag", {31'd0, fifo_is_full}, 32'd1);
    check("full_count", {25'd0, fifo_count}, 32'd64);
    step(1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b1);
    check("full_ovf", {31'd0, ovf}, 32'd1);
    check("full_rdata", fifo_rdata, 32'h100);
    check("full_count63", {25'd0, fifo_count}, 32'd63);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

    // Empty: write+read at empty, read rejected
    step(1'b0, 1'b0, 1'b1, 32'h55, 1'b1);
    check("emp_count", {25'd0, fifo_count}, 32'd1);
    check("emp_udf", {31'd0, udf}, 32'd1);
    check("emp_rdata_hold", fifo_rdata, 32'h100);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("emp_rdata", fifo_rdata, 32'h55);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

    // Wrap: 200 words, random gated traffic
    nw = 0; iter = 0;
    while ((nw < 200 || mq.size() > 0) && iter < 4000) begin
      w = (nw < 200) && ($urandom_range(0, 1) == 1) && (mq.size() < 64);
      r = ($urandom_range(0, 2) != 0) && (mq.size() > 0);
      step(1'b0, 1'b0, w, 32'h1000 + nw, r);
      if (w) nw++;
      iter++;
    end
    check("wrap_done", {31'd0, (iter < 4000)}, 32'd1);
    check("wrap_ovf", {31'd0, ovf}, 32'd0);
    check("wrap_udf", {31'd0, udf}, 32'd0);

    // Flush mid-stream with write pending
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 32'h200 + i, 1'b0);
    check("fl_count10", {25'd0, fifo_count}, 32'd10);
    step(1'b0, 1'b1, 1'b1, 32'h77, 1'b0);
    check("fl_count", {25'd0, fifo_count}, 32'd0);
    check("fl_empty", {31'd0, fifo_is_empty}, 32'd1);

    // Reset mid-stream with write pending
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 32'h300 + i, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h77, 1'b0);
    check("rs_count", {25'd0, fifo_count}, 32'd0);
    check("rs_empty", {31'd0, fifo_is_empty}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
